// File: rtl/led_pwm_bank.sv
// led_pwm_bank: bank of LED outputs with off/on/PWM/breathe modes.
// Shared prescaler and PWM counter; duty double-buffered to period wrap.
module led_pwm_bank #(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clkNIOS,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                write,
  input  logic [31:0]         writedata,
  input  logic                read,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] led
);

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_ON  = 2'b01;
  localparam logic [1:0] M_PWM = 2'b10;
  localparam logic [1:0] M_BRE = 2'b11;

  localparam logic [PWM_BITS-1:0] ONES = '1;
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

  logic                en;
  logic [15:0]         prescale;
  logic [15:0]         pre;
  logic [15:0]         plim;
  logic [PWM_BITS-1:0] cnt;
  logic                tick;
  logic                wrap;
  logic                ctrl_wr;
  logic [CHANNELS-1:0] ch_wr;
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] led_nxt;
  logic [31:0]         rd_nxt;
  logic                unused_bits;

  logic [PWM_BITS-1:0] duty_pend [CHANNELS];
  logic [PWM_BITS-1:0] duty_act  [CHANNELS];
  logic [PWM_BITS-1:0] fade      [CHANNELS];
  logic [1:0]          mode      [CHANNELS];

  assign unused_bits = ^{writedata[31:18], writedata[15:1]};

  // A prescale of 0 behaves like 1; >= keeps a shrunk limit from overrunning.
  assign plim = (prescale == 16'd0) ? 16'd0 : prescale - 16'd1;
  assign tick = en && (pre >= plim);
  assign wrap = tick && (cnt == ONES);

  // Address decode of the write strobe.
  always_comb begin
    ctrl_wr = write && (address == '0);
    ch_wr   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_wr[i] = write && (address == ADDR_W'(i + 1));
    end
  end

  // Control register.
  always_ff @(posedge clkNIOS or negedge reset_n) begin
    if (!reset_n) begin
      en       <= 1'b0;
      prescale <= 16'd0;
    end else if (ctrl_wr) begin
      en       <= writedata[0];
      prescale <= writedata[31:16];
    end
  end

  // Prescaler and PWM counter, held at zero while disabled.
  always_ff @(posedge clkNIOS or negedge reset_n) begin
    if (!reset_n) begin
      pre <= 16'd0;
      cnt <= '0;
    end else if (!en) begin
      pre <= 16'd0;
      cnt <= '0;
    end else if (tick) begin
      pre <= 16'd0;
      cnt <= cnt + ONE;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // Per-channel config, duty shadowing and breathe ramp.
  always_ff @(posedge clkNIOS or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_pend[i] <= '0;
        duty_act[i]  <= '0;
        fade[i]      <= '0;
        mode[i]      <= M_OFF;
      end
      dir <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_wr[i]) begin
          duty_pend[i] <= writedata[PWM_BITS-1:0];
          mode[i]      <= writedata[17:16];
        end
        if (!en || wrap) begin
          duty_act[i] <= duty_pend[i];
        end
        if (ch_wr[i] && (writedata[17:16] == M_BRE)) begin
          fade[i] <= '0;
          dir[i]  <= 1'b0;
        end else if (wrap) begin
          if (!dir[i]) begin
            fade[i] <= fade[i] + ONE;
            if (fade[i] == ONES - ONE) dir[i] <= 1'b1;
          end else begin
            fade[i] <= fade[i] - ONE;
            if (fade[i] == ONE) dir[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Output selection per channel mode.
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (en) begin
        unique case (mode[i])
          M_OFF:   led_nxt[i] = 1'b0;
          M_ON:    led_nxt[i] = 1'b1;
          M_PWM:   led_nxt[i] = cnt < duty_act[i];
          M_BRE:   led_nxt[i] = cnt < fade[i];
          default: led_nxt[i] = 1'b0;
        endcase
      end
    end
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rd_nxt = '0;
    if (address == '0) begin
      rd_nxt = {prescale, 15'd0, en};
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (address == ADDR_W'(i + 1)) begin
        rd_nxt[17:16]         = mode[i];
        rd_nxt[PWM_BITS-1:0]  = duty_pend[i];
      end
    end
  end

  // Registered LED drive and read data.
  always_ff @(posedge clkNIOS or negedge reset_n) begin
    if (!reset_n) begin
      led      <= '0;
      readdata <= '0;
    end else begin
      led <= led_nxt;
      if (read) readdata <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// tb_led_pwm_bank: random and directed checks of led_pwm_bank.
// Period-level model: high counts per PWM period and breathe ramp.
module tb_led_pwm_bank;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        read;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] rd8;
  logic [31:0] rd4;
  logic [7:0]  led8;
  logic [7:0]  led4;

  led_pwm_bank #(.CHANNELS(8), .PWM_BITS(8), .ADDR_W(4)) u_dut8 (
    .clkNIOS(clk), .reset_n(rst_n), .address(address),
    .write(write), .writedata(writedata), .read(read),
    .readdata(rd8), .led(led8)
  );

  led_pwm_bank #(.CHANNELS(8), .PWM_BITS(4), .ADDR_W(4)) u_dut4 (
    .clkNIOS(clk), .reset_n(rst_n), .address(address),
    .write(write), .writedata(writedata), .read(read),
    .readdata(rd4), .led(led4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int hi8 [8];
  int hi4 [8];
  int rise8;
  logic prev0;
  int pw_at;
  logic [3:0]  pw_addr;
  logic [31:0] pw_data;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(logic [3:0] a, output logic [31:0] d8,
                    output logic [31:0] d4);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d8 = rd8; d4 = rd4;
  endtask

  task automatic run(int n);
    for (int c = 0; c < 8; c++) begin
      hi8[c] = 0; hi4[c] = 0;
    end
    rise8 = 0;
    for (int i = 1; i <= n; i++) begin
      if (i == pw_at) begin
        address = pw_addr; writedata = pw_data; write = 1'b1;
      end
      @(posedge clk); #1;
      write = 1'b0;
      for (int c = 0; c < 8; c++) begin
        hi8[c] += int'(led8[c]);
        hi4[c] += int'(led4[c]);
      end
      if (led8[0] && !prev0) rise8++;
      prev0 = led8[0];
    end
    pw_at = 0;
  endtask

  function automatic int tri_f(int k);
    int t;
    t = k % 30;
    return (t <= 15) ? t : 30 - t;
  endfunction

  task automatic check_all_zero(string tag);
    logic [31:0] d8, d4;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d8, d4);
      check({tag, "_rd8"}, d8, 32'd0);
      check({tag, "_rd4"}, d4, 32'd0);
    end
  endtask

  logic [31:0] d8, d4;
  int p, len, d0, d3, nd, pend, act, nxt;
  bit at_wrap;

  initial begin
    rst_n = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0;
    pw_at = 0; pw_addr = '0; pw_data = '0; prev0 = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_led8", {24'd0, led8}, 32'd0);
    check("rst_led4", {24'd0, led4}, 32'd0);
    check("rst_rdata", rd8, 32'd0);
    check_all_zero("rst");

    wr(4'd0, 32'h0003_0001);
    rd(4'd0, d8, d4);
    check("ctrl_rd", d8, 32'h0003_0001);
    @(posedge clk); #1;
    check("ctrl_hold", rd8, 32'h0003_0001);
    wr(4'd0, 32'hFFFF_FFFF);
    rd(4'd0, d8, d4);
    check("ctrl_mask", d8, 32'hFFFF_0001);
    wr(4'd0, 32'd0);

    wr(4'd8, 32'hFFFF_FFA5);
    rd(4'd8, d8, d4);
    check("ch7_rd8", d8, 32'h0003_00A5);
    check("ch7_rd4", d4, 32'h0003_0005);
    wr(4'd9, 32'hFFFF_FFFF);
    rd(4'd9, d8, d4);
    check("a9_rd8", d8, 32'd0);
    check("a9_rd4", d4, 32'd0);
    rd(4'd8, d8, d4);
    check("ch7_keep", d8, 32'h0003_00A5);
    wr(4'd8, 32'd0);

    wr(4'd1, 32'h0002_0040);
    wr(4'd0, 32'h0001_0001);
    run(256);
    check("pwm64_p1", hi8[0], 64);
    check("pwm64_r1", rise8, 1);
    pw_at = 100; pw_addr = 4'd1; pw_data = 32'h0002_00C8;
    run(256);
    check("pwm64_p2", hi8[0], 64);
    check("pwm64_r2", rise8, 1);
    run(256);
    check("pwm200_p3", hi8[0], 200);
    check("pwm200_r3", rise8, 1);

    wr(4'd0, 32'd0);
    wr(4'd2, 32'h0001_0000);
    wr(4'd3, 32'h0000_0000);
    wr(4'd1, 32'h0002_0040);
    wr(4'd0, 32'h0001_0001);
    run(256);
    check("on_ch1", hi8[1], 256);
    check("off_ch2", hi8[2], 0);
    check("pwm_ch0", hi8[0], 64);
    wr(4'd0, 32'd0);
    @(posedge clk); #1;
    check("dis_led8", {24'd0, led8}, 32'd0);
    check("dis_led4", {24'd0, led4}, 32'd0);
    wr(4'd0, 32'h0001_0001);
    run(256);
    check("reen_ch0", hi8[0], 64);
    check("reen_rise", rise8, 1);
    check("reen_ch1", hi8[1], 256);

    for (int it = 0; it < 6; it++) begin
      p  = $urandom_range(1, 3);
      d0 = (it == 0) ? 0 : $urandom_range(0, 255);
      d3 = (it == 0) ? 255 : $urandom_range(0, 255);
      len = 256 * p;
      wr(4'd0, 32'd0);
      wr(4'd1, 32'h0002_0000 | d0);
      wr(4'd4, 32'h0002_0000 | d3);
      wr(4'd0, (p << 16) | 1);
      pend = d0; act = d0;
      for (int k = 0; k < 3; k++) begin
        nd = $urandom_range(0, 255);
        if ($urandom_range(0, 3) == 0) pw_at = len;
        else pw_at = $urandom_range(1, len - 1);
        at_wrap = (pw_at == len);
        pw_addr = 4'd1; pw_data = 32'h0002_0000 | nd;
        run(len);
        check("rnd_ch0", hi8[0], act * p);
        check("rnd_ch3", hi8[3], d3 * p);
        nxt = at_wrap ? pend : nd;
        pend = nd;
        act = nxt;
      end
    end

    wr(4'd0, 32'd0);
    wr(4'd1, 32'h0003_0000);
    wr(4'd0, 32'h0001_0001);
    for (int k = 0; k < 34; k++) begin
      run(16);
      check("bre_ramp", hi4[0], tri_f(k));
    end
    pw_at = 15; pw_addr = 4'd1; pw_data = 32'h0003_0000;
    run(16);
    check("bre_pre", hi4[0], tri_f(34));
    for (int m = 1; m < 6; m++) begin
      run(16);
      check("bre_restart", hi4[0], tri_f(m));
    end

    wr(4'd0, 32'd0);
    wr(4'd2, 32'h0001_0000);
    wr(4'd0, 32'h0001_0001);
    run(5);
    check("pre_rst_on", {31'd0, led8[1]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_led8", {24'd0, led8}, 32'd0);
    check("arst_led4", {24'd0, led4}, 32'd0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("arst");
    run(20);
    check("arst_off", hi8[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
